// File: rtl/mult8x8_job_feeder.sv
// Job sequencer: queues operand pairs, drives top_level_8x8 one job at a time and
// presents each product on a valid/ready result port. Watchdog: MULT_FEED_TIMEOUT_EN.
module mult8x8_job_feeder #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   reset_a,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_a,
    input  logic [7:0]             in_b,
    output logic [7:0]             mul_dataa,
    output logic [7:0]             mul_datab,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic [15:0]            mul_product,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [15:0]            res_product,
    output logic                   res_err,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_illegal
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t          state_r;
    logic [7:0]      mem_a_r [DEPTH];
    logic [7:0]      mem_b_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic [7:0]      mul_dataa_r;
    logic [7:0]      mul_datab_r;
    logic            mul_start_r;
    logic            res_valid_r;
    logic [15:0]     res_product_r;
    logic            res_err_r;
    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;

`ifdef MULT_FEED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [WW-1:0] WD_ONE  = WW'(1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
    logic [WW-1:0]   wd_cnt_r;
`endif

    // FIFO status and pop decision; a pop only ever comes from IDLE or a completed HOLD.
    always_comb begin
        full_s  = (count_r == CNT_FULL);
        empty_s = (count_r == {CW{1'b0}});
        push_s  = in_valid && !full_s;
        case (state_r)
            ST_IDLE: pop_s = !empty_s;
            ST_HOLD: pop_s = res_valid_r && res_ready && !empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // Operand storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_a_r[wr_ptr_r] <= in_a;
            mem_b_r[wr_ptr_r] <= in_b;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Job sequencer FSM with registered multiplier and result outputs.
    always_ff @(posedge clk) begin
        if (reset_a) begin
            state_r       <= ST_IDLE;
            mul_dataa_r   <= 8'h00;
            mul_datab_r   <= 8'h00;
            mul_start_r   <= 1'b0;
            res_valid_r   <= 1'b0;
            res_product_r <= 16'h0000;
            res_err_r     <= 1'b0;
`ifdef MULT_FEED_TIMEOUT_EN
            wd_cnt_r      <= {WW{1'b0}};
`endif
        end else begin
            // Operands move only on a pop, so they stay put from START through capture.
            mul_start_r <= pop_s;
            if (pop_s) begin
                mul_dataa_r <= mem_a_r[rd_ptr_r];
                mul_datab_r <= mem_b_r[rd_ptr_r];
            end
            case (state_r)
                ST_IDLE: begin
                    if (pop_s) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    state_r <= ST_WAIT;
`ifdef MULT_FEED_TIMEOUT_EN
                    wd_cnt_r <= {WW{1'b0}};
`endif
                end
                ST_WAIT: begin
                    if (mul_done) begin
                        res_product_r <= mul_product;
                        res_err_r     <= 1'b0;
                        res_valid_r   <= 1'b1;
                        state_r       <= ST_HOLD;
                    end
`ifdef MULT_FEED_TIMEOUT_EN
                    else if (wd_cnt_r == WD_LAST) begin
                        res_product_r <= 16'h0000;
                        res_err_r     <= 1'b1;
                        res_valid_r   <= 1'b1;
                        state_r       <= ST_HOLD;
                    end else begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end
`endif
                end
                ST_HOLD: begin
                    if (res_valid_r && res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= pop_s ? ST_START : ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign in_ready    = !full_s;
    assign busy        = (state_r != ST_IDLE) || !empty_s;
    assign fifo_count  = count_r;
    assign mul_dataa   = mul_dataa_r;
    assign mul_datab   = mul_datab_r;
    assign mul_start   = mul_start_r;
    assign res_valid   = res_valid_r;
    assign res_product = res_product_r;
    assign res_err     = res_err_r;

endmodule

// File: tb/tb_mult8x8_job_feeder.sv
// Directed bench for mult8x8_job_feeder with a cycle-level stand-in for top_level_8x8
// (samples start, raises done_flag four edges later with the product).
module tb_mult8x8_job_feeder;

    logic        clk = 1'b0;
    logic        reset_a = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = 8'd0;
    logic [7:0]  in_b = 8'd0;
    logic [7:0]  mul_dataa;
    logic [7:0]  mul_datab;
    logic        mul_start;
    logic        mul_done;
    logic [15:0] mul_product;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [15:0] res_product;
    logic        res_err;
    logic        busy;
    logic [2:0]  fifo_count;

    always #5 clk = ~clk;

    mult8x8_job_feeder #(.DEPTH(4), .TIMEOUT(15)) dut (
        .clk(clk), .reset_a(reset_a),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mul_dataa(mul_dataa), .mul_datab(mul_datab), .mul_start(mul_start),
        .mul_done(mul_done), .mul_product(mul_product),
        .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
        .res_err(res_err), .busy(busy), .fifo_count(fifo_count)
    );

    // Multiplier stand-in: m_lat edges after sampling start it pulses done (unless stuck).
    int unsigned m_cnt = 0;
    int unsigned m_lat = 4;
    bit          m_stuck = 1'b0;
    logic        m_done = 1'b0;
    logic [15:0] m_prod = 16'd0;
    assign mul_done    = m_done;
    assign mul_product = m_prod;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (mul_start) begin
            m_cnt <= 1;
        end else if (m_cnt != 0) begin
            if (m_cnt == m_lat) begin
                m_cnt <= 0;
                if (!m_stuck) begin
                    m_done <= 1'b1;
                    m_prod <= {8'd0, mul_dataa} * {8'd0, mul_datab};
                end
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    int cyc = 0;
    int start_cnt = 0;
    int rv_cnt = 0;
    int fifo_max = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mul_start) start_cnt <= start_cnt + 1;
        if (res_valid) rv_cnt <= rv_cnt + 1;
        if (int'(fifo_count) > fifo_max) fifo_max <= int'(fifo_count);
    end

    int pass_cnt = 0;
    int chk_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_rv(input int budget);
        for (int k = 0; k < budget; k++) begin
            if (res_valid) break;
            @(negedge clk);
        end
    endtask

    logic [7:0]  ba [5] = '{8'd255, 8'd16, 8'd0,   8'd1, 8'd3};
    logic [7:0]  bb [5] = '{8'd255, 8'd16, 8'd200, 8'd1, 8'd5};
    logic [15:0] exp_q [6] = '{16'd203, 16'd65025, 16'd256, 16'd0, 16'd1, 16'd15};
    logic [15:0] got_q [6];
    int          hs_cyc [6];
    int          n;
    int          s0;
    int          rv0;
    bit          stable;
    bit          got_push;
    bit          any_err;

    initial begin
        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_a = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_res_valid", res_valid, 0);
        check("rst_mul_start", mul_start, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_res_product", res_product, 0);

        // Single job 29*7, accepted at E0
        s0 = start_cnt;
        in_valid = 1'b1; in_a = 8'd29; in_b = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("e0_fifo_count", fifo_count, 1);
        @(negedge clk);
        check("e1_mul_start", mul_start, 1);
        check("e1_dataa", mul_dataa, 29);
        check("e1_datab", mul_datab, 7);
        @(negedge clk);
        check("e2_mul_start_low", mul_start, 0);
        repeat (4) @(negedge clk);
        check("e6_res_valid_low", res_valid, 0);
        @(negedge clk);
        check("e7_res_valid", res_valid, 1);
        check("e7_res_product", res_product, 203);
        check("e7_res_err", res_err, 0);
        check("single_start_pulses", start_cnt - s0, 1);

        // Burst while the result is held: only four pairs fit
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = ba[i]; in_b = bb[i];
            check("burst_in_ready", in_ready, 1);
            @(negedge clk);
        end
        in_a = ba[4]; in_b = bb[4];
        check("burst_full_ready", in_ready, 0);
        check("burst_full_count", fifo_count, 4);

        // Result hold for 20 cycles with no handshake
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (!(res_valid === 1'b1 && res_product === 16'd203 && res_err === 1'b0)) stable = 1'b0;
            @(negedge clk);
        end
        check("hold_stable", stable, 1);
        check("hold_no_start", start_cnt - s0, 1);

        // Drain: 203 then the burst in order
        res_ready = 1'b1;
        n = 0;
        any_err = 1'b0;
        for (int k = 0; k < 100 && n < 6; k++) begin
            got_push = in_valid && in_ready;
            if (res_valid) begin
                got_q[n] = res_product;
                hs_cyc[n] = cyc;
                if (res_err !== 1'b0) any_err = 1'b1;
                n++;
            end
            @(negedge clk);
            if (got_push) in_valid = 1'b0;
        end
        check("drain_count", n, 6);
        for (int i = 0; i < 6; i++) check("drain_product", got_q[i], exp_q[i]);
        check("drain_err", any_err, 0);
        check("drain_throughput", hs_cyc[3] - hs_cyc[2], 7);
        check("drain_fifo_max", fifo_max, 4);
        check("drain_idle_busy", busy, 0);
        check("drain_pulses", start_cnt - s0, 6);

`ifdef MULT_FEED_TIMEOUT_EN
        // Watchdog: done never arrives
        res_ready = 1'b0;
        m_stuck = 1'b1;
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("wd_start", mul_start, 1);
        repeat (15) @(negedge clk);
        check("wd_early", res_valid, 0);
        @(negedge clk);
        check("wd_valid", res_valid, 1);
        check("wd_err", res_err, 1);
        check("wd_product", res_product, 0);
        m_stuck = 1'b0;
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd4; in_b = 8'd4;
        @(negedge clk);
        in_valid = 1'b0;
        wait_rv(30);
        check("wd_next_valid", res_valid, 1);
        check("wd_next_product", res_product, 16);
        check("wd_next_err", res_err, 0);
        @(negedge clk);
`else
        // Without the watchdog a slow multiplier is simply waited for
        res_ready = 1'b1;
        m_lat = 30;
        in_valid = 1'b1; in_a = 8'd2; in_b = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("slow_no_result", res_valid, 0);
        check("slow_busy", busy, 1);
        wait_rv(40);
        check("slow_valid", res_valid, 1);
        check("slow_product", res_product, 6);
        check("slow_err", res_err, 0);
        m_lat = 4;
        @(negedge clk);
`endif

        // Reset during the first WAIT cycle
        res_ready = 1'b1;
        in_valid = 1'b1; in_a = 8'd5; in_b = 8'd5;
        @(negedge clk);
        in_a = 8'd6; in_b = 8'd6;
        @(negedge clk);
        in_a = 8'd7; in_b = 8'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("mid_count", fifo_count, 2);
        check("mid_busy", busy, 1);
        reset_a = 1'b1;
        @(negedge clk);
        reset_a = 1'b0;
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", res_valid, 0);
        check("mid_rst_dataa", mul_dataa, 0);
        rv0 = rv_cnt;
        repeat (12) @(negedge clk);
        check("mid_no_result", rv_cnt - rv0, 0);
        check("mid_still_idle", busy, 0);
        in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        wait_rv(30);
        check("post_rst_valid", res_valid, 1);
        check("post_rst_product", res_product, 81);
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
